// File: rtl/cell_address_allocator_pkg.sv
// Shared types for the cell address allocator: default-width cell address and allocator FSM states.
package cell_address_allocator_pkg;

  localparam int unsigned NBR_OF_PORTS_DEF  = 4;
  localparam int unsigned ADDRESSES_DEF     = 32;
  localparam int unsigned ADDRESS_WIDTH_DEF = $clog2(ADDRESSES_DEF);

  typedef logic [ADDRESS_WIDTH_DEF-1:0] cell_addr_t;

  typedef enum logic {
    ALLOC_INIT,
    ALLOC_RUN
  } alloc_state_t;

endpackage

// File: rtl/free_list_fifo.sv
// Circular free-address list: push at tail, pop at head, occupancy count derives full/empty.
module free_list_fifo #(
  parameter int depth = 32,
  parameter int aw    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [aw-1:0] push_data,
  input  logic          pop,
  output logic [aw-1:0] head_data,
  output logic [aw:0]   count
);

  logic [aw-1:0] mem [depth];
  logic [aw-1:0] head_q, head_d;
  logic [aw-1:0] tail_q, tail_d;
  logic [aw:0]   count_q, count_d;

  // NOTE: storage is left unreset; only the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= push_data;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_d  = head_q + aw'(pop);
    tail_d  = tail_q + aw'(push);
    count_d = count_q + (aw+1)'(push) - (aw+1)'(pop);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem[head_q];
  assign count     = count_q;

endmodule

// File: rtl/cell_address_allocator.sv
// Free-address pool for the shared cell buffer: init fill, round-robin grants, checked release.
module cell_address_allocator
  import cell_address_allocator_pkg::*;
#(
  parameter int nbrOfPorts   = 4,
  parameter int addresses    = 32,
  parameter int addressWidth = $clog2(addresses)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [nbrOfPorts-1:0]   allocReq,
  output logic [nbrOfPorts-1:0]   allocGnt,
  output logic [addressWidth-1:0] allocAddr,
  input  logic                    freeValid,
  input  logic [addressWidth-1:0] freeAddr,
  output logic                    initDone,
  output logic [addressWidth:0]   freeCount,
  output logic                    errDoubleFree
);

  localparam int pw = $clog2(nbrOfPorts);

  alloc_state_t            state_q, state_d;
  logic [addressWidth-1:0] init_cnt_q, init_cnt_d;
  logic [addresses-1:0]    in_use_q, in_use_d;
  logic [pw-1:0]           rr_q, rr_d;
  logic [nbrOfPorts-1:0]   gnt_q, gnt_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic                    init_done_q, init_done_d;
  logic                    err_q, err_d;

  logic                    fifo_push, fifo_pop;
  logic [addressWidth-1:0] fifo_push_data, fifo_head;
  logic [addressWidth:0]   fifo_count;

  logic [nbrOfPorts-1:0]   eligible;
  logic [pw-1:0]           win, cand;
  logic                    found;

  free_list_fifo #(
    .depth (addresses),
    .aw    (addressWidth)
  ) u_free_list (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    in_use_d       = in_use_q;
    rr_d           = rr_q;
    gnt_d          = '0;
    addr_d         = addr_q;
    init_done_d    = (state_q == ALLOC_RUN);
    err_d          = 1'b0;
    fifo_push      = 1'b0;
    fifo_push_data = init_cnt_q;
    fifo_pop       = 1'b0;

    // The registered grant doubles as last-granted mask: the winner sits out one cycle.
    eligible = allocReq & ~gnt_q;
    win      = '0;
    cand     = '0;
    found    = 1'b0;
    for (int i = 0; i < nbrOfPorts; i++) begin
      cand = pw'((int'(rr_q) + i) % nbrOfPorts);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_q)
      ALLOC_INIT: begin
        fifo_push      = 1'b1;
        fifo_push_data = init_cnt_q;
        init_cnt_d     = init_cnt_q + 1'b1;
        if (init_cnt_q == addressWidth'(addresses - 1)) state_d = ALLOC_RUN;
      end
      ALLOC_RUN: begin
        if (found && fifo_count != '0) begin
          fifo_pop            = 1'b1;
          gnt_d[win]          = 1'b1;
          addr_d              = fifo_head;
          in_use_d[fifo_head] = 1'b1;
          rr_d                = pw'((int'(win) + 1) % nbrOfPorts);
        end
        // A popped address is never in use, so the set above and this clear cannot collide.
        if (freeValid) begin
          if (in_use_q[freeAddr]) begin
            fifo_push          = 1'b1;
            fifo_push_data     = freeAddr;
            in_use_d[freeAddr] = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ALLOC_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ALLOC_INIT;
      init_cnt_q  <= '0;
      in_use_q    <= '0;
      rr_q        <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      in_use_q    <= in_use_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign allocGnt      = gnt_q;
  assign allocAddr     = addr_q;
  assign initDone      = init_done_q;
  assign freeCount     = fifo_count;
  assign errDoubleFree = err_q;

endmodule

// File: tb/tb_cell_address_allocator.sv
// Directed bench for cell_address_allocator: init latency, round-robin order, free/double-free, reset.
module tb_cell_address_allocator;
  import cell_address_allocator_pkg::*;

  logic       clk;
  logic       rstn;
  logic [3:0] allocReq;
  logic [3:0] allocGnt;
  cell_addr_t allocAddr;
  logic       freeValid;
  cell_addr_t freeAddr;
  logic       initDone;
  logic [5:0] freeCount;
  logic       errDoubleFree;

  int n_vec  = 0;
  int n_miss = 0;

  cell_address_allocator #(
    .nbrOfPorts   (4),
    .addresses    (32),
    .addressWidth (5)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .allocReq      (allocReq),
    .allocGnt      (allocGnt),
    .allocAddr     (allocAddr),
    .freeValid     (freeValid),
    .freeAddr      (freeAddr),
    .initDone      (initDone),
    .freeCount     (freeCount),
    .errDoubleFree (errDoubleFree)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rstn is released 1 time unit after a rising edge; the next edge is edge 1.
  task automatic wait_init();
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (initDone === 1'b1) break;
    end
    check("init_latency", n, 33);
    check("init_free_count", freeCount, 32);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   allocGnt, 0);
    check({tag, "_addr"},  allocAddr, 0);
    check({tag, "_done"},  initDone, 0);
    check({tag, "_count"}, freeCount, 0);
    check({tag, "_err"},   errDoubleFree, 0);
  endtask

  initial begin
    rstn      = 1'b0;
    allocReq  = '0;
    freeValid = 1'b0;
    freeAddr  = '0;

    // Reset state and init latency
    repeat (3) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    wait_init();

    // Round-robin over all 32 addresses with every port requesting
    allocReq = 4'b1111;
    for (int i = 0; i < 32; i++) begin
      tick();
      check($sformatf("rr_gnt_%0d", i), allocGnt, 32'(4'b0001 << (i % 4)));
      check($sformatf("rr_addr_%0d", i), allocAddr, i);
    end
    check("drained_count", freeCount, 0);

    // Empty list: no grant; a free makes the address grantable two cycles later
    allocReq = 4'b0100;
    tick();
    check("empty_gnt", allocGnt, 0);
    check("empty_count", freeCount, 0);
    check("empty_addr_hold", allocAddr, 31);
    freeValid = 1'b1;
    freeAddr  = 5'd7;
    tick();
    freeValid = 1'b0;
    check("free7_no_bypass_gnt", allocGnt, 0);
    check("free7_count", freeCount, 1);
    check("free7_err", errDoubleFree, 0);
    tick();
    check("free7_gnt", allocGnt, 4'b0100);
    check("free7_addr", allocAddr, 7);
    check("free7_count_after", freeCount, 0);
    allocReq = 4'b0000;

    // Double free of address 5
    freeValid = 1'b1;
    freeAddr  = 5'd5;
    tick();
    check("free5_first_err", errDoubleFree, 0);
    check("free5_first_count", freeCount, 1);
    tick();
    freeValid = 1'b0;
    check("free5_second_err", errDoubleFree, 1);
    check("free5_second_count", freeCount, 1);
    tick();
    check("free5_err_pulse", errDoubleFree, 0);
    check("free5_count_final", freeCount, 1);

    // Build list 5,10..18 (count 10), then pop and push in the same cycle
    for (int a = 10; a <= 18; a++) begin
      freeValid = 1'b1;
      freeAddr  = cell_addr_t'(a);
      tick();
    end
    freeValid = 1'b0;
    check("fill10_count", freeCount, 10);
    allocReq  = 4'b0001;
    freeValid = 1'b1;
    freeAddr  = 5'd20;
    tick();
    check("simul_gnt", allocGnt, 4'b0001);
    check("simul_addr", allocAddr, 5);
    check("simul_count", freeCount, 10);
    allocReq  = 4'b1111;
    freeValid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("fifo_addr_%0d", k), allocAddr, (k < 9) ? 10 + k : 20);
      check($sformatf("fifo_gnt_%0d", k), 32'(|allocGnt), 1);
    end
    allocReq = 4'b0000;
    check("fifo_drained_count", freeCount, 0);

    // Bring the pool to 20 allocated, then reset in the middle of traffic
    for (int a = 0; a < 12; a++) begin
      freeValid = 1'b1;
      freeAddr  = cell_addr_t'(a);
      tick();
    end
    check("pre_reset_count", freeCount, 12);
    allocReq  = 4'b1111;
    freeValid = 1'b1;
    freeAddr  = 5'd12;
    #3;
    rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    allocReq  = 4'b0000;
    freeValid = 1'b0;
    repeat (2) tick();
    check("midrst_hold_count", freeCount, 0);
    rstn = 1'b1;
    wait_init();
    check("reinit_gnt", allocGnt, 0);

    // After reset nothing is in use, so any release is a double free
    freeValid = 1'b1;
    freeAddr  = 5'd3;
    tick();
    freeValid = 1'b0;
    check("post_reset_err", errDoubleFree, 1);
    check("post_reset_count", freeCount, 32);
    tick();
    check("post_reset_err_pulse", errDoubleFree, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
